e_stage_ctrl_md: RTL and testbench

//   Parametrised next-generation E-stage controller: decodes E_instruction into ALU/mux/

---
 rtl/e_stage_ctrl_md_pkg.sv | 52 +++++
 rtl/e_stage_ctrl_md_md_seq.sv | 38 +++
 rtl/e_stage_ctrl_md.sv | 102 ++++++++++
 tb/tb_e_stage_ctrl_md.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/e_stage_ctrl_md_pkg.sv
// e_stage_ctrl_md_pkg: opcode/funct constants and control encodings shared by the pipeline controllers
package e_stage_ctrl_md_pkg;
  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_SLT   = 6'h2a;
  localparam logic [5:0] F_SLTU  = 6'h2b;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_LUI  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_XOR  = 4'd7
  } alu_op_t;
  typedef enum logic [1:0] {D2_RDATA2 = 2'd0, D2_SEXT = 2'd1, D2_ZEXT = 2'd2} data2_sel_t;
  typedef enum logic [1:0] {WD_ALU = 2'd0, WD_MEM = 2'd1, WD_PC8 = 2'd2, WD_MDU = 2'd3} wdata_sel_t;
  typedef enum logic [1:0] {MD_MULT = 2'd0, MD_MULTU = 2'd1, MD_DIV = 2'd2, MD_DIVU = 2'd3} md_op_t;
  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;
endpackage

// File: rtl/e_stage_ctrl_md_md_seq.sv
// e_stage_ctrl_md_md_seq: mult/div occupancy FSM with busy countdown
module e_stage_ctrl_md_md_seq import e_stage_ctrl_md_pkg::*; #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  output logic         busy
);
  localparam int CW = $clog2(DIV_CYCLES + 1);
  md_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  // state and countdown registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  // load the latency on start, count down while busy, release when the last cycle expires
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == MD_IDLE) begin
      state_n = start ? MD_BUSY : MD_IDLE;
      cnt_n   = !start ? cnt : (op inside {MD_DIV, MD_DIVU}) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else begin
      state_n = (cnt == CW'(1)) ? MD_IDLE : MD_BUSY;
      cnt_n   = cnt - 1'b1;
    end
  end
  assign busy = (state == MD_BUSY);
endmodule

// File: rtl/e_stage_ctrl_md.sv
// e_stage_ctrl_md: E-stage decode plus mult/div start, busy and D-stage stall control
module e_stage_ctrl_md import e_stage_ctrl_md_pkg::*; #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int ALU_OP_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         E_instruction,
  input  logic                E_valid,
  input  logic                D_is_md,
  output logic [ALU_OP_W-1:0] E_op,
  output logic [1:0]          s_E_data2,
  output logic [15:0]         E_imm16,
  output logic [1:0]          E_T_new,
  output logic [4:0]          E_Wreg,
  output logic                E_GRF_WE,
  output logic [1:0]          s_E_GRF_Wdata,
  output logic                E_is_LW,
  output logic                E_is_SW,
  output logic                md_start,
  output logic [1:0]          md_op,
  output logic [1:0]          hilo_we,
  output logic                md_busy,
  output logic                stall_md
);
  logic [5:0] opcode, funct;
  logic [4:0] rt, rd, wr;
  logic unused_fields;
  alu_op_t op;
  data2_sel_t d2;
  logic rw, iw, ld, st, jl, mf, arith, mth, mtl, we;
  assign opcode        = E_instruction[31:26];
  assign funct         = E_instruction[5:0];
  assign rt            = E_instruction[20:16];
  assign rd            = E_instruction[15:11];
  assign unused_fields = ^{E_instruction[25:21], E_instruction[10:6]};
  // classify the instruction; anything unrecognised stays a nop
  always_comb begin
    op    = ALU_ADD;
    d2    = D2_RDATA2;
    rw    = 1'b0;
    iw    = 1'b0;
    ld    = 1'b0;
    st    = 1'b0;
    jl    = 1'b0;
    mf    = 1'b0;
    arith = 1'b0;
    mth   = 1'b0;
    mtl   = 1'b0;
    case (opcode)
      OP_R: case (funct)
        F_ADD, F_ADDU: rw = 1'b1;
        F_SUB, F_SUBU: begin rw = 1'b1; op = ALU_SUB; end
        F_AND:         begin rw = 1'b1; op = ALU_AND; end
        F_OR:          begin rw = 1'b1; op = ALU_OR; end
        F_XOR:         begin rw = 1'b1; op = ALU_XOR; end
        F_SLT:         begin rw = 1'b1; op = ALU_SLT; end
        F_SLTU:        begin rw = 1'b1; op = ALU_SLTU; end
        F_MFHI, F_MFLO: mf = 1'b1;
        F_MTHI:        mth = 1'b1;
        F_MTLO:        mtl = 1'b1;
        F_MULT, F_MULTU, F_DIV, F_DIVU: arith = 1'b1;
        default: ;
      endcase
      OP_ADDI, OP_ADDIU: begin iw = 1'b1; d2 = D2_SEXT; end
      OP_SLTI:  begin iw = 1'b1; d2 = D2_SEXT; op = ALU_SLT; end
      OP_SLTIU: begin iw = 1'b1; d2 = D2_SEXT; op = ALU_SLTU; end
      OP_ANDI:  begin iw = 1'b1; d2 = D2_ZEXT; op = ALU_AND; end
      OP_ORI:   begin iw = 1'b1; d2 = D2_ZEXT; op = ALU_OR; end
      OP_XORI:  begin iw = 1'b1; d2 = D2_ZEXT; op = ALU_XOR; end
      OP_LUI:   begin iw = 1'b1; d2 = D2_ZEXT; op = ALU_LUI; end
      OP_LW, OP_LH, OP_LB: begin ld = 1'b1; d2 = D2_SEXT; end
      OP_SW, OP_SH, OP_SB: begin st = 1'b1; d2 = D2_SEXT; end
      OP_BEQ, OP_BNE: op = ALU_SUB;
      OP_JAL: jl = 1'b1;
      default: ;
    endcase
  end
  assign we            = rw | mf | iw | ld | jl;
  assign wr            = (rw | mf) ? rd : (iw | ld) ? rt : jl ? 5'd31 : 5'd0;
  assign E_op          = ALU_OP_W'(op);
  assign s_E_data2     = d2;
  assign E_imm16       = E_instruction[15:0];
  assign E_T_new       = !E_valid ? 2'd0 : ld ? 2'd2 : (rw | mf | iw) ? 2'd1 : 2'd0;
  assign E_GRF_WE      = E_valid & we;
  assign E_Wreg        = E_GRF_WE ? wr : 5'd0;
  assign s_E_GRF_Wdata = ld ? WD_MEM : jl ? WD_PC8 : mf ? WD_MDU : WD_ALU;
  assign E_is_LW       = E_valid & ld;
  assign E_is_SW       = E_valid & st;
  assign md_start      = E_valid & arith & ~md_busy;
  assign md_op         = funct[1:0];
  assign hilo_we       = {2{E_valid & ~md_busy}} & {mth, mtl};
  assign stall_md      = D_is_md & (md_busy | md_start);
  e_stage_ctrl_md_md_seq #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_seq (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .op    (md_op),
    .busy  (md_busy)
  );
endmodule

// File: tb/tb_e_stage_ctrl_md.sv
// tb_e_stage_ctrl_md: directed scoreboard bench for the E-stage controller
module tb_e_stage_ctrl_md;
  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] MULT  = 32'h0109_0018;
  localparam logic [31:0] MULTU = 32'h0109_0019;
  localparam logic [31:0] DIV   = 32'h0109_001a;
  localparam logic [31:0] MFLO  = 32'h0000_5012;
  localparam logic [31:0] MTHI  = 32'h0100_0011;
  localparam logic [31:0] MTLO  = 32'h0100_0013;
  localparam logic [31:0] ORI   = 32'h3509_ffff;
  localparam logic [31:0] JAL   = 32'h0c00_0100;
  localparam logic [31:0] LH    = 32'h8509_0004;
  localparam logic [31:0] SUB   = 32'h0109_5022;
  localparam logic [31:0] SLT   = 32'h0109_502a;
  localparam logic [31:0] SW    = 32'had09_0000;
  localparam logic [31:0] LUI   = 32'h3c09_1234;
  localparam logic [31:0] BEQ   = 32'h1109_0003;
  localparam logic [31:0] BAD   = 32'hfc00_0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] ins = NOP;
  logic v = 1'b0;
  logic dmd = 1'b0;
  logic [3:0] E_op;
  logic [1:0] s_E_data2, E_T_new, s_E_GRF_Wdata, md_op, hilo_we;
  logic [15:0] E_imm16;
  logic [4:0] E_Wreg;
  logic E_GRF_WE, E_is_LW, E_is_SW, md_start, md_busy, stall_md;
  logic [28:0] act, m_all, m_dec, m_md, m_mo, m_hw, m_en, m_jal;
  typedef struct {
    string       tag;
    logic [28:0] ev;
    logic [28:0] em;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  e_stage_ctrl_md dut (
    .clk           (clk),
    .reset         (reset),
    .E_instruction (ins),
    .E_valid       (v),
    .D_is_md       (dmd),
    .E_op          (E_op),
    .s_E_data2     (s_E_data2),
    .E_imm16       (E_imm16),
    .E_T_new       (E_T_new),
    .E_Wreg        (E_Wreg),
    .E_GRF_WE      (E_GRF_WE),
    .s_E_GRF_Wdata (s_E_GRF_Wdata),
    .E_is_LW       (E_is_LW),
    .E_is_SW       (E_is_SW),
    .md_start      (md_start),
    .md_op         (md_op),
    .hilo_we       (hilo_we),
    .md_busy       (md_busy),
    .stall_md      (stall_md)
  );
  always #5 clk = ~clk;
  assign act = {dut.u_seq.cnt, E_op, s_E_data2, E_T_new, E_Wreg, E_GRF_WE, s_E_GRF_Wdata,
                E_is_LW, E_is_SW, md_start, md_op, hilo_we, md_busy, stall_md};
  // cnt, E_op, s_E_data2, E_T_new, E_Wreg, E_GRF_WE, s_E_GRF_Wdata, lw, sw, md_start, md_op, hilo_we, md_busy, stall_md
  function automatic logic [28:0] pk(input logic [3:0] c, input logic [3:0] op, input logic [1:0] d2,
                                     input logic [1:0] tn, input logic [4:0] wr, input logic we,
                                     input logic [1:0] wd, input logic lw, input logic sw, input logic ms,
                                     input logic [1:0] mo, input logic [1:0] hw, input logic bz, input logic st);
    return {c, op, d2, tn, wr, we, wd, lw, sw, ms, mo, hw, bz, st};
  endfunction
  task automatic step(input logic r, input logic [31:0] i, input logic vv, input logic dm,
                      input string tag, input logic [28:0] ev, input logic [28:0] em);
    @(posedge clk);
    #1;
    reset = r;
    ins   = i;
    v     = vv;
    dmd   = dm;
    if (em != '0) q.push_back(exp_t'{tag, ev, em});
  endtask
  // monitor: compare the oldest expectation against the DUT mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if ((act & e.em) !== (e.ev & e.em)) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (mask %h)", e.tag, act & e.em, e.ev & e.em, e.em);
      end
    end
  end
  initial begin
    m_all = '1;
    m_mo  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 0, 0, 0);
    m_dec = ~m_mo;
    m_md  = pk(4'hf, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    m_hw  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 0, 0);
    m_en  = pk(0, 0, 0, 2'd3, 5'h1f, 1, 0, 1, 1, 1, 0, 2'd3, 0, 0);
    m_jal = pk(0, 0, 0, 2'd3, 5'h1f, 1, 2'd3, 1, 1, 1, 0, 2'd3, 0, 0);
    step(1, NOP, 0, 0, "", '0, '0);
    step(1, NOP, 0, 0, "rst_idle", '0, m_all);
    step(0, MULT, 1, 0, "t1_start", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), m_md | m_mo);
    step(0, NOP, 0, 0, "t1_busy5", pk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), m_md);
    step(1, NOP, 0, 1, "t1_cnt4", pk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), m_md);
    step(1, NOP, 0, 1, "t1_rst_a", '0, m_md);
    step(1, NOP, 0, 1, "t1_rst_b", '0, m_md);
    step(0, NOP, 0, 1, "t1_after", '0, m_md);
    step(0, MULT, 1, 1, "t2_start", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1), m_md | m_mo);
    for (int i = 1; i <= 5; i++)
      step(0, NOP, 0, 1, "t2_stall", pk(4'(6 - i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), m_md);
    step(0, NOP, 0, 1, "t2_release", '0, m_md);
    step(0, DIV, 1, 1, "t3_start", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 0, 0, 1), m_md | m_mo);
    for (int i = 1; i <= 10; i++)
      step(0, NOP, 0, 1, "t3_busy", pk(4'(11 - i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), m_md);
    step(0, NOP, 0, 1, "t3_free", '0, m_md);
    step(0, MFLO, 1, 0, "t3_mflo", pk(0, 0, 0, 1, 10, 1, 2'd3, 0, 0, 0, 0, 0, 0, 0), m_dec);
    step(0, ORI, 1, 0, "t4_ori", pk(0, 2, 2, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0), m_dec);
    step(0, ORI, 0, 0, "t4_ori_bubble", '0, m_en);
    step(0, JAL, 1, 0, "t5_jal", pk(0, 0, 0, 0, 31, 1, 2'd2, 0, 0, 0, 0, 0, 0, 0), m_jal);
    step(0, LH, 1, 0, "t5_lh", pk(0, 0, 1, 2, 9, 1, 1, 1, 0, 0, 0, 0, 0, 0), m_dec);
    step(0, SUB, 1, 0, "dec_sub", pk(0, 1, 0, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0), m_dec);
    step(0, SLT, 1, 0, "dec_slt", pk(0, 5, 0, 1, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0), m_dec);
    step(0, SW, 1, 0, "dec_sw", pk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), m_dec);
    step(0, LUI, 1, 0, "dec_lui", pk(0, 3, 2, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0), m_dec);
    step(0, BEQ, 1, 0, "dec_beq", pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), m_dec);
    step(0, BAD, 1, 0, "dec_unknown", '0, m_dec);
    step(0, MTLO, 1, 0, "dec_mtlo", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd1, 0, 0), m_dec);
    step(0, MULTU, 1, 0, "t6_start", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 0, 0, 0), m_md | m_mo);
    step(0, MULTU, 1, 0, "t6_ignored_a", pk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), m_md);
    step(0, MULTU, 1, 0, "t6_ignored_b", pk(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), m_md);
    step(0, MTHI, 1, 0, "t6_mthi_busy", pk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), m_md | m_hw);
    step(0, NOP, 0, 0, "t6_cnt2", pk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), m_md);
    step(0, NOP, 0, 0, "t6_cnt1", pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), m_md);
    step(0, MULT, 0, 1, "t6_idle", '0, m_md);
    step(0, MTHI, 1, 0, "dec_mthi", pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 0, 0), m_dec);
    step(0, NOP, 0, 0, "", '0, '0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
